boreal_apex_ctrl: RTL and testbench
===================================

BOREAL_APEX_CTRL -- requirements
Module: boreal_apex_ctrl

Interface
REQ-001 SHALL have parameter WARMUP_N, default 16: forwarded samples required before lock, legal range 1..65535.
REQ-002 SHALL have parameter WDOG_LIMIT, default 1024: idle-cycle timeout in TRACK (used only with BOREAL_CTRL_WDOG_EN).
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_valid  in  1  upstream sample valid.
REQ-007 s_ready  out  1  upstream sample ready.
REQ-008 s_x, s_y  in  16 each, signed  upstream X/Y sample.
REQ-009 decim  in  4  forward one of every decim+1 accepted samples.
REQ-010 start, halt_req, clear  in  1 each  session start, halt request, halt release.
REQ-011 core_valid  out  1  one-cycle sample strobe to the 2D adaptive core.
REQ-012 core_x, core_y  out  16 each, signed  sample to core.
REQ-013 core_halt  out  1  drives the core's emergency halt (zeroes core state).
REQ-014 state  out  2  FSM state; locked  out  1  TRACK indicator; sample_cnt  out  16  forwarded-sample count; wdog_trip  out  1  sticky timeout flag.

Function
REQ-015 States SHALL be IDLE=0, WARMUP=1, TRACK=2, HALT=3.
REQ-016 IDLE->WARMUP when start=1; start SHALL be ignored in all other states.
REQ-017 WARMUP->TRACK on the cycle the WARMUP_N-th forwarded sample is issued; sample_cnt SHALL equal WARMUP_N at that edge.
REQ-018 Any state->HALT when halt_req=1; halt_req SHALL take priority over start, clear and transfers.
REQ-019 HALT->IDLE when clear=1 and halt_req=0; otherwise remain in HALT.
REQ-020 s_ready SHALL be combinational: 1 only in WARMUP or TRACK with halt_req=0; a transfer is s_valid&&s_ready.
REQ-021 4-bit decimation counter dcnt: on each transfer, if dcnt>=decim the sample is forwarded and dcnt<=0, else dcnt<=dcnt+1; decim=0 forwards every sample; the >= compare covers decim lowered mid-run.
REQ-022 Forwarded sample SHALL appear on core_x/core_y with core_valid=1 exactly one cycle after the transfer edge; core_valid SHALL be a single-cycle pulse per forwarded sample.
REQ-023 core_x/core_y SHALL hold the last forwarded values between strobes.
REQ-024 core_halt SHALL be 1 in IDLE and HALT, 0 in WARMUP and TRACK (decoded from registered state).
REQ-025 sample_cnt SHALL increment per forwarded sample, saturate at 0xFFFF, and clear to 0 on entry to WARMUP.
REQ-026 locked SHALL equal (state==TRACK).
REQ-027 dcnt SHALL clear to 0 on entry to WARMUP and on entry to HALT.
REQ-028 A transfer accepted on the cycle before HALT entry SHALL still produce its core_valid pulse; no core_valid SHALL be issued while in HALT or IDLE otherwise.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, core_valid=0, core_x=core_y=0, dcnt=0, sample_cnt=0, wdog_trip=0, watchdog counter=0, independent of clk.
REQ-030 Reset mid-WARMUP or mid-TRACK SHALL discard any pending strobe; after release the block SHALL wait in IDLE for start.

Configuration
REQ-031 With BOREAL_CTRL_WDOG_EN defined: in TRACK, a counter SHALL count cycles without a transfer, clear on each transfer, and on reaching WDOG_LIMIT force HALT and set wdog_trip; wdog_trip SHALL stay set until the HALT->IDLE transition.
REQ-032 Without BOREAL_CTRL_WDOG_EN: no watchdog logic; wdog_trip SHALL be tied 0; TRACK SHALL persist indefinitely without samples.

Verification
REQ-033 Reset, start, decim=0, WARMUP_N=16, 16 back-to-back samples -> 16 core_valid pulses each 1 cycle after transfer; state=TRACK, locked=1, sample_cnt=16.
REQ-034 TRACK, decim=3, 12 samples x=1..12 -> core_valid on x=4, 8, 12 only; core_x holds 12 afterwards.
REQ-035 halt_req asserted together with s_valid and start -> s_ready=0, next state=HALT, core_halt=1; clear with halt_req=1 -> stays HALT; clear alone -> IDLE.
REQ-036 rst_n pulsed low mid-cycle during WARMUP with sample_cnt=7 -> all outputs zero immediately, state=IDLE, no core_valid after release.
REQ-037 With BOREAL_CTRL_WDOG_EN, WDOG_LIMIT=1024, TRACK with no s_valid for 1024 cycles -> HALT and wdog_trip=1; without macro, 5000 idle cycles -> stays TRACK, wdog_trip=0.

Source files
------------

// File: rtl/boreal_apex_ctrl_if.sv
// Sample stream bundle: upstream X/Y samples in, one-cycle strobed samples out to the 2D adaptive core.
// valid/ready: upstream s_x/s_y move only on a cycle where s_valid && s_ready; core_valid has no back-pressure.
interface boreal_apex_ctrl_if;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_x;
  logic signed [15:0] s_y;
  logic               core_valid;
  logic signed [15:0] core_x;
  logic signed [15:0] core_y;

  modport master (
    output s_valid, s_x, s_y,
    input  s_ready, core_valid, core_x, core_y
  );

  modport slave (
    input  s_valid, s_x, s_y,
    output s_ready, core_valid, core_x, core_y
  );
endinterface

// File: rtl/boreal_apex_ctrl.sv
// Session controller feeding a 2D adaptive core: warm-up, lock, decimation and emergency halt.
// Optional idle watchdog in TRACK is compiled in with macro BOREAL_CTRL_WDOG_EN.
module boreal_apex_ctrl #(
  parameter int unsigned WARMUP_N   = 16,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  boreal_apex_ctrl_if.slave   bus,
  input  logic [3:0]          decim,
  input  logic                start,
  input  logic                halt_req,
  input  logic                clear,
  output logic                core_halt,
  output logic [1:0]          state,
  output logic                locked,
  output logic [15:0]         sample_cnt,
  output logic                wdog_trip
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_TRACK  = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [16:0] LP_WARMUP_N = 17'(WARMUP_N);

  state_t             r_state;
  logic [3:0]         r_dcnt;
  logic [15:0]        r_sample_cnt;
  logic               r_core_valid;
  logic signed [15:0] r_core_x;
  logic signed [15:0] r_core_y;

  logic               w_active;
  logic               w_ready;
  logic               w_xfer;
  logic               w_fwd;
  logic [15:0]        w_cnt_inc;
  logic               w_warm_done;
  logic               w_wdog_fire;

  assign w_active    = (r_state == ST_WARMUP) || (r_state == ST_TRACK);
  assign w_ready     = w_active && !halt_req;
  assign w_xfer      = bus.s_valid && w_ready;
  // >= rather than == so a decim lowered mid-run still forwards promptly
  assign w_fwd       = w_xfer && (r_dcnt >= decim);
  assign w_cnt_inc   = (r_sample_cnt == 16'hFFFF) ? r_sample_cnt : r_sample_cnt + 16'd1;
  assign w_warm_done = ({1'b0, r_sample_cnt} + 17'd1) == LP_WARMUP_N;

`ifdef BOREAL_CTRL_WDOG_EN
  localparam int unsigned        LP_WDW  = $clog2(WDOG_LIMIT + 1);
  localparam logic [LP_WDW-1:0]  LP_LAST = LP_WDW'(WDOG_LIMIT - 1);

  logic [LP_WDW-1:0] r_wdog_cnt;
  logic              r_wdog_trip;

  assign w_wdog_fire = (r_state == ST_TRACK) && !w_xfer && (r_wdog_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt  <= '0;
      r_wdog_trip <= 1'b0;
    end else begin
      if ((r_state != ST_TRACK) || w_xfer || w_wdog_fire) begin
        r_wdog_cnt <= '0;
      end else begin
        r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
      // sticky until the operator releases HALT back to IDLE
      if (w_wdog_fire) begin
        r_wdog_trip <= 1'b1;
      end else if ((r_state == ST_HALT) && clear && !halt_req) begin
        r_wdog_trip <= 1'b0;
      end
    end
  end

  assign wdog_trip = r_wdog_trip;
`else
  assign w_wdog_fire = 1'b0;
  assign wdog_trip   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dcnt       <= 4'd0;
      r_sample_cnt <= 16'd0;
      r_core_valid <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
    end else begin
      // a transfer needs halt_req=0, so a strobe is never born on a halting edge
      r_core_valid <= w_fwd;
      if (w_fwd) begin
        r_core_x <= bus.s_x;
        r_core_y <= bus.s_y;
      end
      if (halt_req || w_wdog_fire) begin
        r_state <= ST_HALT;
        r_dcnt  <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state      <= ST_WARMUP;
              r_dcnt       <= 4'd0;
              r_sample_cnt <= 16'd0;
            end
          end
          ST_WARMUP, ST_TRACK: begin
            if (w_xfer) begin
              r_dcnt <= w_fwd ? 4'd0 : r_dcnt + 4'd1;
            end
            if (w_fwd) begin
              r_sample_cnt <= w_cnt_inc;
              if ((r_state == ST_WARMUP) && w_warm_done) begin
                r_state <= ST_TRACK;
              end
            end
          end
          ST_HALT: begin
            if (clear) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.s_ready    = w_ready;
  assign bus.core_valid = r_core_valid;
  assign bus.core_x     = r_core_x;
  assign bus.core_y     = r_core_y;
  assign state          = r_state;
  assign locked         = (r_state == ST_TRACK);
  assign core_halt      = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign sample_cnt     = r_sample_cnt;

endmodule

// File: tb/tb_boreal_apex_ctrl.sv
// Self-checking bench for boreal_apex_ctrl: random stimulus against a rule-level session model.
module tb_boreal_apex_ctrl;
  localparam int WARMUP_N   = 16;
  localparam int WDOG_LIMIT = 1024;

  logic        clk;
  logic        rst_n;
  logic [3:0]  decim;
  logic        start;
  logic        halt_req;
  logic        clear;
  logic        core_halt;
  logic [1:0]  state;
  logic        locked;
  logic [15:0] sample_cnt;
  logic        wdog_trip;

  boreal_apex_ctrl_if bus ();

  boreal_apex_ctrl #(
    .WARMUP_N   (WARMUP_N),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .decim      (decim),
    .start      (start),
    .halt_req   (halt_req),
    .clear      (clear),
    .core_halt  (core_halt),
    .state      (state),
    .locked     (locked),
    .sample_cnt (sample_cnt),
    .wdog_trip  (wdog_trip)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // session model: phase 0=idle 1=warmup 2=track 3=halt
  int          m_phase;
  int          m_skip;
  int          m_fwd_total;
  bit          m_cv;
  bit          m_trip;
  int          m_idle;
  logic [15:0] m_cx;
  logic [15:0] m_cy;
  logic [31:0] exp_q[$];
  int          errors;
  int          checks;

  function automatic bit model_ready();
    return ((m_phase == 1) || (m_phase == 2)) && !halt_req;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_skip = 0; m_fwd_total = 0; m_cv = 0; m_trip = 0; m_idle = 0;
    m_cx = 16'd0; m_cy = 16'd0;
    exp_q.delete();
  endtask

  task automatic drive(input bit v, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] d, input bit st, input bit hr, input bit cl);
    bus.s_valid = v; bus.s_x = x; bus.s_y = y;
    decim = d; start = st; halt_req = hr; clear = cl;
  endtask

  // advance one clock, applying the session rules to the inputs currently driven
  task automatic tick();
    bit xfer, fwd;
    int next_phase;
    xfer = bus.s_valid && model_ready();
    fwd  = xfer && (m_skip >= int'(decim));
    next_phase = m_phase;
    if (halt_req) begin
      next_phase = 3; m_skip = 0;
    end else if (m_phase == 0) begin
      if (start) begin next_phase = 1; m_skip = 0; m_fwd_total = 0; end
    end else if (m_phase == 3) begin
      if (clear) begin next_phase = 0; m_trip = 0; end
    end else if (xfer) begin
      if (fwd) begin
        m_skip = 0;
        if (m_fwd_total < 65535) m_fwd_total++;
        if ((m_phase == 1) && (m_fwd_total == WARMUP_N)) next_phase = 2;
      end else begin
        m_skip++;
      end
    end
`ifdef BOREAL_CTRL_WDOG_EN
    if ((m_phase == 2) && !xfer) begin
      m_idle++;
      if (m_idle == WDOG_LIMIT) begin next_phase = 3; m_trip = 1; m_skip = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
`endif
    m_cv = fwd;
    if (fwd) begin
      m_cx = bus.s_x; m_cy = bus.s_y;
      exp_q.push_back({bus.s_x, bus.s_y});
    end
    @(posedge clk);
    #1;
    m_phase = next_phase;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (bus.core_valid !== 1'b0) begin errors++; $display("FAIL reset_core_valid got=%b exp=0", bus.core_valid); end
    checks++; if ({bus.core_x, bus.core_y} !== 32'd0) begin errors++; $display("FAIL reset_core_xy got=%h exp=0", {bus.core_x, bus.core_y}); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_sample_cnt got=%0d exp=0", sample_cnt); end
    checks++; if (core_halt !== 1'b1 || locked !== 1'b0 || wdog_trip !== 1'b0) begin
      errors++; $display("FAIL reset_flags got halt=%b locked=%b trip=%b exp 1/0/0", core_halt, locked, wdog_trip);
    end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
  endtask

  task automatic test_warmup();
    logic [31:0] got, exp;
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (state !== 2'd1 || core_halt !== 1'b0) begin errors++; $display("FAIL warmup_entry got state=%0d halt=%b exp 1/0", state, core_halt); end
    for (int i = 0; i < WARMUP_N; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (bus.core_valid !== 1'b1) begin errors++; $display("FAIL warmup_strobe[%0d] got=%b exp=1", i, bus.core_valid); end
      if (bus.core_valid === 1'b1 && exp_q.size() > 0) begin
        exp = exp_q.pop_front(); got = {bus.core_x, bus.core_y};
        checks++; if (got !== exp) begin errors++; $display("FAIL warmup_data[%0d] got=%h exp=%h", i, got, exp); end
      end
      checks++; if (state !== 2'(m_phase)) begin errors++; $display("FAIL warmup_state[%0d] got=%0d exp=%0d", i, state, m_phase); end
    end
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 2'd2 || locked !== 1'b1) begin errors++; $display("FAIL warmup_lock got state=%0d locked=%b exp 2/1", state, locked); end
    checks++; if (sample_cnt !== 16'(WARMUP_N)) begin errors++; $display("FAIL warmup_count got=%0d exp=%0d", sample_cnt, WARMUP_N); end
  endtask

  task automatic test_decim();
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 16'(i), 16'($urandom), 4'd3, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (bus.core_valid !== ((i % 4) == 0)) begin
        errors++; $display("FAIL decim_strobe x=%0d got=%b exp=%b", i, bus.core_valid, (i % 4) == 0);
      end
      if (bus.core_valid === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    drive(1'b0, 16'd0, 16'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (bus.core_x !== 16'd12 || bus.core_valid !== 1'b0) begin
      errors++; $display("FAIL decim_hold got x=%0d valid=%b exp 12/0", bus.core_x, bus.core_valid);
    end
    checks++; if (sample_cnt !== 16'(WARMUP_N + 3)) begin errors++; $display("FAIL decim_count got=%0d exp=%0d", sample_cnt, WARMUP_N + 3); end
  endtask

  task automatic test_track_idle();
    int bad;
    bad = 0;
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (state !== 2'(m_phase) || bus.core_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_trace got=%0d bad cycles exp=0", bad); end
`ifdef BOREAL_CTRL_WDOG_EN
    checks++; if (state !== 2'd3 || wdog_trip !== 1'b1) begin errors++; $display("FAIL idle_wdog got state=%0d trip=%b exp 3/1", state, wdog_trip); end
`else
    checks++; if (state !== 2'd2 || wdog_trip !== 1'b0) begin errors++; $display("FAIL idle_track got state=%0d trip=%b exp 2/0", state, wdog_trip); end
`endif
    checks++; if (wdog_trip !== m_trip) begin errors++; $display("FAIL idle_trip_model got=%b exp=%b", wdog_trip, m_trip); end
  endtask

  task automatic test_halt();
    drive(1'b1, 16'h1234, 16'h5678, 4'd0, 1'b1, 1'b1, 1'b0);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL halt_ready got=%b exp=0", bus.s_ready); end
    tick();
    checks++; if (state !== 2'd3 || core_halt !== 1'b1) begin errors++; $display("FAIL halt_entry got state=%0d halt=%b exp 3/1", state, core_halt); end
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL halt_hold got=%0d exp=3", state); end
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (state !== 2'd0 || wdog_trip !== 1'b0) begin errors++; $display("FAIL halt_release got state=%0d trip=%b exp 0/0", state, wdog_trip); end
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    drive(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'($urandom_range(1, 32767)), 16'($urandom_range(1, 32767)), 4'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checks++; if (sample_cnt !== 16'd7 || bus.core_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got cnt=%0d valid=%b exp 7/1", sample_cnt, bus.core_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || bus.core_valid !== 1'b0 || sample_cnt !== 16'd0 || {bus.core_x, bus.core_y} !== 32'd0 || locked !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got state=%0d valid=%b cnt=%0d xy=%h exp all zero", state, bus.core_valid, sample_cnt, {bus.core_x, bus.core_y});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.core_valid !== 1'b0 || state !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_after got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_random();
    int bad_ready, bad_state, bad_valid, bad_data, bad_cnt, bad_flags;
    logic [31:0] exp;
    logic [3:0]  d;
    bad_ready = 0; bad_state = 0; bad_valid = 0; bad_data = 0; bad_cnt = 0; bad_flags = 0;
    d = 4'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) d = 4'($urandom_range(0, 4));
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), d,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0));
      #1;
      if (bus.s_ready !== model_ready()) bad_ready++;
      tick();
      if (state !== 2'(m_phase)) bad_state++;
      if (bus.core_valid !== m_cv) bad_valid++;
      if (bus.core_valid === 1'b1) begin
        if (exp_q.size() == 0) bad_data++;
        else begin
          exp = exp_q.pop_front();
          if ({bus.core_x, bus.core_y} !== exp) bad_data++;
        end
      end
      if ({bus.core_x, bus.core_y} !== {m_cx, m_cy}) bad_data++;
      if (sample_cnt !== 16'(m_fwd_total)) bad_cnt++;
      if (locked !== (m_phase == 2) || core_halt !== (m_phase == 0 || m_phase == 3) || wdog_trip !== m_trip) bad_flags++;
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL rand_ready got=%0d bad cycles exp=0", bad_ready); end
    checks++; if (bad_state != 0) begin errors++; $display("FAIL rand_state got=%0d bad cycles exp=0", bad_state); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL rand_strobe got=%0d bad cycles exp=0", bad_valid); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL rand_data got=%0d bad cycles exp=0", bad_data); end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL rand_count got=%0d bad cycles exp=0", bad_cnt); end
    checks++; if (bad_flags != 0) begin errors++; $display("FAIL rand_flags got=%0d bad cycles exp=0", bad_flags); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_warmup();
    test_decim();
    test_track_idle();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
